repairable_memory: RTL and testbench
====================================

Name: repairable_memory

Overview:
- Parametrised synchronous single-port word memory used as the MBIST/MBISR target.
- Adds a spare-word remap table for built-in repair, so accesses to a repaired address are steered to a spare word.
- Adds stuck-at fault injection on the main array, so the BIST engine has real faults to find and repair.
- Adds a configurable read latency with a read-valid strobe; sits between the BIST/repair controller and the functional port.

Parameters:
ADDR_WIDTH, 5, address bits.
DATA_WIDTH, 8, word width.
MEM_SIZE, 32, main array words (≤ 2**ADDR_WIDTH).
NUM_SPARES, 4, spare words / remap entries (≥1).
NUM_FAULTS, 2, fault-injection entries (≥1).
READ_LAT, 1, read latency in cycles (1 or 2).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mem_en  in  1  access enable
mem_we  in  1  1=write, 0=read (qualified by mem_en)
mem_addr  in  ADDR_WIDTH  access address
mem_wdata  in  DATA_WIDTH  write data
mem_rdata  out  DATA_WIDTH  read data
mem_rvalid  out  1  one-cycle strobe, mem_rdata valid
repair_req  in  1  request remap of repair_addr
repair_addr  in  ADDR_WIDTH  faulty address to remap
repair_ack  out  1  one-cycle strobe, request accepted
repair_err  out  1  one-cycle strobe, request rejected (table full)
repair_full  out  1  all spares allocated
repair_count  out  $clog2(NUM_SPARES+1)  spares in use
fault_we  in  1  write fault entry
fault_idx  in  $clog2(NUM_FAULTS) (min 1)  entry index
fault_en  in  1  entry enable
fault_addr  in  ADDR_WIDTH  faulty main-array address
fault_bit  in  $clog2(DATA_WIDTH) (min 1)  faulty bit
fault_val  in  1  stuck-at value

Behaviour:
- Reset:
  - Clears main array, spares, remap table, fault table and repair_count.
  - Forces all outputs to 0, including the read pipeline.
- Address decode per access, using the remap table as it stood at the start of the cycle:
  - If mem_addr matches a valid remap entry, the access targets that spare word.
  - Otherwise, if mem_addr < MEM_SIZE, it targets the main array.
  - Otherwise it is out-of-range.
- Write (mem_en & mem_we):
  - Updates the target word.
  - Out-of-range writes are ignored.
  - No rvalid is produced.
- Read (mem_en & ~mem_we):
  - Sampled this cycle; mem_rdata/mem_rvalid appear READ_LAT cycles later.
  - rvalid is high for exactly one cycle per read; back-to-back reads are fully pipelined.
  - Out-of-range reads return 0 with rvalid=1.
  - mem_rdata holds its value when no read completes.
- Read-after-write to the same address in the next cycle returns the new data. No same-cycle forwarding is needed (single port).
- Fault injection applies to main-array reads only:
  - For each enabled entry whose fault_addr equals the address, the read data bit fault_bit is forced to fault_val.
  - When entries overlap, the higher index wins.
  - Stored data is unaffected.
  - Spare reads are never faulted, so remapping masks the fault.
  - fault_we updates an entry at the clock edge; it takes effect for reads sampled from the next cycle.
- Repair:
  - repair_req sampled each cycle; ack/err asserted the following cycle.
  - If repair_addr is already mapped: ack, no allocation.
  - Else if not full: allocate entry repair_count, set valid, clear that spare word to 0, increment repair_count, ack.
  - Else: err, table unchanged.
  - A new mapping affects accesses from the cycle after repair_req.
  - A same-cycle access to repair_addr uses the old mapping.
  - repair_full = (repair_count == NUM_SPARES).
  - repair_addr ≥ MEM_SIZE is accepted like any other address.
- Reset asserted mid-operation discards in-flight reads: no rvalid follows.
- Mapping persists until reset; there is no unmap.

Decomposition:
- Shared package mbist_pkg holds:
  - the remap entry struct {valid, addr};
  - the fault entry struct {en, addr, bit, val};
  - the width helper constants for the clog2 widths.
- One natural sub-module, spare_remap_cam. It holds the remap table plus allocation logic and outputs hit and hit_idx.

Test Plan:
- Write 0xA5 to addr 3, read addr 3 -> mem_rdata=0xA5 with rvalid exactly READ_LAT cycles later. Repeat for READ_LAT=1 and READ_LAT=2.
- Fault entry 0 = {en=1, addr=5, bit=2, val=0}; write 0xFF to addr 5, read -> 0xFB.
- Same fault setup, then repair_req addr 5 -> repair_ack next cycle, repair_count=1. Write 0xFF to addr 5, read -> 0xFF. Addr 6 is unaffected.
- NUM_SPARES=4: repair addrs 1,2,3,4 -> four acks, repair_full=1. Repair addr 7 -> repair_err, count stays 4. Repeat repair addr 2 -> ack, count stays 4.
- Read addr 40 with MEM_SIZE=32, ADDR_WIDTH=6 -> rdata=0, rvalid=1. Write to addr 40 -> no array change.
- Issue a read then assert rst the next cycle -> no rvalid, all outputs 0. Subsequent read of addr 3 -> 0x00.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types and width helpers for the repairable memory and its remap CAM.
package mbist_pkg;

  // Table fields are stored at a fixed maximum width; callers zero-extend into them.
  localparam int ADDR_MAX_W = 16;
  localparam int BIT_MAX_W  = 8;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_MAX_W-1:0] addr;
  } remap_entry_t;

  typedef struct packed {
    logic                  en;
    logic [ADDR_MAX_W-1:0] addr;
    logic [BIT_MAX_W-1:0]  bit_sel;
    logic                  val;
  } fault_entry_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spare_remap_cam.sv
// Spare-word remap table: address lookup plus in-order spare allocation.
module spare_remap_cam import mbist_pkg::*; #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_SPARES = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ADDR_WIDTH-1:0]                 lookup_addr,
  output logic                                  hit,
  output logic [clog2_min1(NUM_SPARES)-1:0]     hit_idx,
  input  logic                                  req,
  input  logic [ADDR_WIDTH-1:0]                 req_addr,
  output logic                                  ack,
  output logic                                  err,
  output logic                                  full,
  output logic [$clog2(NUM_SPARES+1)-1:0]       count,
  output logic                                  alloc,
  output logic [clog2_min1(NUM_SPARES)-1:0]     alloc_idx
);
  localparam int IW = clog2_min1(NUM_SPARES);
  localparam int CW = $clog2(NUM_SPARES+1);

  remap_entry_t   tbl [NUM_SPARES];
  logic [CW-1:0]  cnt;
  logic           req_hit;

  // Match both the access address and the repair address against valid entries.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    req_hit = 1'b0;
    for (int i = 0; i < NUM_SPARES; i++) begin
      if (tbl[i].valid && tbl[i].addr == ADDR_MAX_W'(lookup_addr)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (tbl[i].valid && tbl[i].addr == ADDR_MAX_W'(req_addr))
        req_hit = 1'b1;
    end
  end

  assign full      = (cnt == CW'(NUM_SPARES));
  assign alloc     = req && !req_hit && !full;
  assign alloc_idx = cnt[IW-1:0];
  assign count     = cnt;

  // Allocate the next free entry; an already-mapped address is acked without allocating.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPARES; i++) tbl[i] <= '0;
      cnt <= '0;
      ack <= 1'b0;
      err <= 1'b0;
    end else begin
      ack <= req && (req_hit || !full);
      err <= req && !req_hit && full;
      if (alloc) begin
        tbl[alloc_idx] <= '{valid: 1'b1, addr: ADDR_MAX_W'(req_addr)};
        cnt            <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/repairable_memory.sv
// Single-port word memory with spare-word repair, stuck-at fault injection
// on the main array, and a 1- or 2-cycle read pipeline.
module repairable_memory import mbist_pkg::*; #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 32,
  parameter int NUM_SPARES = 4,
  parameter int NUM_FAULTS = 2,
  parameter int READ_LAT   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  mem_en,
  input  logic                                  mem_we,
  input  logic [ADDR_WIDTH-1:0]                 mem_addr,
  input  logic [DATA_WIDTH-1:0]                 mem_wdata,
  output logic [DATA_WIDTH-1:0]                 mem_rdata,
  output logic                                  mem_rvalid,
  input  logic                                  repair_req,
  input  logic [ADDR_WIDTH-1:0]                 repair_addr,
  output logic                                  repair_ack,
  output logic                                  repair_err,
  output logic                                  repair_full,
  output logic [$clog2(NUM_SPARES+1)-1:0]       repair_count,
  input  logic                                  fault_we,
  input  logic [clog2_min1(NUM_FAULTS)-1:0]     fault_idx,
  input  logic                                  fault_en,
  input  logic [ADDR_WIDTH-1:0]                 fault_addr,
  input  logic [clog2_min1(DATA_WIDTH)-1:0]     fault_bit,
  input  logic                                  fault_val
);
  localparam int IW = clog2_min1(NUM_SPARES);
  localparam int MW = clog2_min1(MEM_SIZE);
  localparam int BW = clog2_min1(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] main_mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] spare    [NUM_SPARES];
  fault_entry_t          ftab     [NUM_FAULTS];

  logic                  hit, alloc, in_range, rd_now;
  logic [IW-1:0]         hit_idx, alloc_idx;
  logic [MW-1:0]         mem_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [READ_LAT:1]     vld_pipe;
  logic [DATA_WIDTH-1:0] data_pipe [1:READ_LAT];

  spare_remap_cam #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_SPARES(NUM_SPARES)) u_cam (
    .clk(clk), .rst(rst),
    .lookup_addr(mem_addr), .hit(hit), .hit_idx(hit_idx),
    .req(repair_req), .req_addr(repair_addr),
    .ack(repair_ack), .err(repair_err), .full(repair_full), .count(repair_count),
    .alloc(alloc), .alloc_idx(alloc_idx)
  );

  assign in_range = {1'b0, mem_addr} < (ADDR_WIDTH+1)'(MEM_SIZE);
  assign mem_idx  = mem_addr[MW-1:0];
  assign rd_now   = mem_en && !mem_we;

  // Read word: spare on a remap hit, else main array with faults overlaid (later entry wins).
  always_comb begin
    rd_word = '0;
    if (hit) begin
      rd_word = spare[hit_idx];
    end else if (in_range) begin
      rd_word = main_mem[mem_idx];
      for (int f = 0; f < NUM_FAULTS; f++) begin
        if (ftab[f].en && ftab[f].addr == ADDR_MAX_W'(mem_addr) &&
            ftab[f].bit_sel < BIT_MAX_W'(DATA_WIDTH))
          rd_word[ftab[f].bit_sel[BW-1:0]] = ftab[f].val;
      end
    end
  end

  // Storage writes, spare clear on allocation, and fault table updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_SIZE; i++)   main_mem[i] <= '0;
      for (int i = 0; i < NUM_SPARES; i++) spare[i]    <= '0;
      for (int i = 0; i < NUM_FAULTS; i++) ftab[i]     <= '0;
    end else begin
      if (mem_en && mem_we) begin
        if (hit)           spare[hit_idx]    <= mem_wdata;
        else if (in_range) main_mem[mem_idx] <= mem_wdata;
      end
      // The allocated entry is not yet valid, so it never collides with the write above.
      if (alloc) spare[alloc_idx] <= '0;
      if (fault_we && int'(fault_idx) < NUM_FAULTS)
        ftab[fault_idx] <= '{en: fault_en, addr: ADDR_MAX_W'(fault_addr),
                             bit_sel: BIT_MAX_W'(fault_bit), val: fault_val};
    end
  end

  // Read pipeline; data stages only load behind a valid so the output holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int k = 1; k <= READ_LAT; k++) data_pipe[k] <= '0;
    end else begin
      vld_pipe[1] <= rd_now;
      if (rd_now) data_pipe[1] <= rd_word;
      for (int k = 2; k <= READ_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) data_pipe[k] <= data_pipe[k-1];
      end
    end
  end

  assign mem_rvalid = vld_pipe[READ_LAT];
  assign mem_rdata  = data_pipe[READ_LAT];

endmodule

// File: tb/tb_repairable_memory.sv
// Bench for repairable_memory: two instances (READ_LAT 1 and 2, 6-bit address,
// 32-word array) share stimulus and are checked against one behavioural model.
module tb_repairable_memory;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_en = 0, mem_we = 0, repair_req = 0, fault_we = 0, fault_en = 0, fault_val = 0;
  logic [5:0] mem_addr = 0, repair_addr = 0, fault_addr = 0;
  logic [7:0] mem_wdata = 0;
  logic [0:0] fault_idx = 0;
  logic [2:0] fault_bit = 0;

  logic [7:0] rdata_a, rdata_b;
  logic       rvalid_a, rvalid_b, ack_a, ack_b, err_a, err_b, full_a, full_b;
  logic [2:0] count_a, count_b;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  repairable_memory #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .MEM_SIZE(32), .NUM_SPARES(4),
                      .NUM_FAULTS(2), .READ_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(rdata_a), .mem_rvalid(rvalid_a),
    .repair_req(repair_req), .repair_addr(repair_addr), .repair_ack(ack_a),
    .repair_err(err_a), .repair_full(full_a), .repair_count(count_a),
    .fault_we(fault_we), .fault_idx(fault_idx), .fault_en(fault_en),
    .fault_addr(fault_addr), .fault_bit(fault_bit), .fault_val(fault_val));

  repairable_memory #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .MEM_SIZE(32), .NUM_SPARES(4),
                      .NUM_FAULTS(2), .READ_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(rdata_b), .mem_rvalid(rvalid_b),
    .repair_req(repair_req), .repair_addr(repair_addr), .repair_ack(ack_b),
    .repair_err(err_b), .repair_full(full_b), .repair_count(count_b),
    .fault_we(fault_we), .fault_idx(fault_idx), .fault_en(fault_en),
    .fault_addr(fault_addr), .fault_bit(fault_bit), .fault_val(fault_val));

  // Behavioural model: arrays plus an ordered list of repaired addresses.
  logic [7:0] mm [32];
  logic [7:0] sp [4];
  int         map_a [4];
  int         nmap;
  logic       f_en [2];
  int         f_addr [2], f_bit [2];
  logic       f_val [2];
  // Expected visible outputs: a = 1-cycle latency, b = 2-cycle latency (pb = b's middle stage).
  logic       ea_v, eb_v, pb_v, e_ack, e_err;
  logic [7:0] ea_d, eb_d, pb_d;

  function automatic int map_find(int a);
    for (int i = 0; i < nmap; i++) if (map_a[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [7:0] model_read(int a);
    logic [7:0] d;
    int m;
    m = map_find(a);
    if (m >= 0) return sp[m];
    if (a >= 32) return 8'h00;
    d = mm[a];
    for (int i = 0; i < 2; i++) if (f_en[i] && f_addr[i] == a) d[f_bit[i]] = f_val[i];
    return d;
  endfunction

  // Apply one clock of the current inputs to the model and advance the DUTs.
  task automatic tick();
    logic nv;
    logic [7:0] nd;
    int m;
    nv = mem_en && !mem_we;
    nd = model_read(int'(mem_addr));
    e_ack = 0; e_err = 0;
    if (rst) begin
      for (int i = 0; i < 32; i++) mm[i] = 0;
      for (int i = 0; i < 4; i++) begin sp[i] = 0; map_a[i] = -1; end
      for (int i = 0; i < 2; i++) begin f_en[i] = 0; f_addr[i] = 0; f_bit[i] = 0; f_val[i] = 0; end
      nmap = 0;
      ea_v = 0; eb_v = 0; pb_v = 0; ea_d = 0; eb_d = 0; pb_d = 0;
    end else begin
      if (mem_en && mem_we) begin
        m = map_find(int'(mem_addr));
        if (m >= 0) sp[m] = mem_wdata;
        else if (mem_addr < 32) mm[mem_addr[4:0]] = mem_wdata;
      end
      if (repair_req) begin
        if (map_find(int'(repair_addr)) >= 0) e_ack = 1;
        else if (nmap < 4) begin
          map_a[nmap] = int'(repair_addr); sp[nmap] = 0; nmap++; e_ack = 1;
        end else e_err = 1;
      end
      if (fault_we) begin
        f_en[fault_idx] = fault_en; f_addr[fault_idx] = int'(fault_addr);
        f_bit[fault_idx] = int'(fault_bit); f_val[fault_idx] = fault_val;
      end
      eb_v = pb_v; if (pb_v) eb_d = pb_d;
      pb_v = nv;   if (nv) pb_d = nd;
      ea_v = nv;   if (nv) ea_d = nd;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    mem_en = 0; mem_we = 0; repair_req = 0; fault_we = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rdata_a, rvalid_a, ack_a, err_a, full_a, count_a} !== 15'd0 ||
        {rdata_b, rvalid_b, ack_b, err_b, full_b, count_b} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: a=%h/%b/%b/%b/%b/%0d b=%h/%b/%b/%b/%b/%0d want all 0",
               rdata_a, rvalid_a, ack_a, err_a, full_a, count_a,
               rdata_b, rvalid_b, ack_b, err_b, full_b, count_b);
    end
  endtask

  task automatic test_basic();
    idle(); mem_en = 1; mem_we = 1; mem_addr = 3; mem_wdata = 8'hA5; tick();
    mem_we = 0; tick();
    checks++;
    if (rvalid_a !== 1'b1 || rdata_a !== 8'hA5 || rvalid_b !== 1'b0) begin
      failures++;
      $display("FAIL basic_lat1: a=%h/%b b_vld=%b want a5/1 b_vld=0", rdata_a, rvalid_a, rvalid_b);
    end
    idle(); tick();
    checks++;
    if (rvalid_b !== 1'b1 || rdata_b !== 8'hA5 || rvalid_a !== 1'b0 || rdata_a !== 8'hA5) begin
      failures++;
      $display("FAIL basic_lat2: b=%h/%b a=%h/%b want b a5/1 a a5/0", rdata_b, rvalid_b, rdata_a, rvalid_a);
    end
  endtask

  task automatic test_fault();
    idle(); fault_we = 1; fault_idx = 0; fault_en = 1; fault_addr = 5; fault_bit = 2; fault_val = 0; tick();
    idle(); mem_en = 1; mem_we = 1; mem_addr = 5; mem_wdata = 8'hFF; tick();
    mem_we = 0; tick();
    checks++;
    if (rdata_a !== 8'hFB || rvalid_a !== 1'b1) begin
      failures++; $display("FAIL fault_rd_a: got %h/%b want fb/1", rdata_a, rvalid_a);
    end
    idle(); tick();
    checks++;
    if (rdata_b !== 8'hFB || rvalid_b !== 1'b1) begin
      failures++; $display("FAIL fault_rd_b: got %h/%b want fb/1", rdata_b, rvalid_b);
    end
  endtask

  task automatic test_repair();
    idle(); mem_en = 1; mem_we = 1; mem_addr = 6; mem_wdata = 8'h66; tick();
    idle(); repair_req = 1; repair_addr = 5; tick();
    checks++;
    if (ack_a !== 1'b1 || err_a !== 1'b0 || count_a !== 3'd1 || ack_b !== 1'b1 || count_b !== 3'd1) begin
      failures++;
      $display("FAIL repair_ack: a=%b/%b/%0d b=%b/%0d want 1/0/1 1/1", ack_a, err_a, count_a, ack_b, count_b);
    end
    idle(); mem_en = 1; mem_we = 1; mem_addr = 5; mem_wdata = 8'hFF; tick();
    checks++;
    if (ack_a !== 1'b0) begin
      failures++; $display("FAIL repair_ack_pulse: got %b want 0", ack_a);
    end
    mem_we = 0; tick();
    mem_addr = 6; tick();
    checks++;
    if (rdata_a !== 8'h66 || rdata_b !== 8'hFF || rvalid_b !== 1'b1) begin
      failures++;
      $display("FAIL repair_masks: a(6)=%h b(5)=%h/%b want 66 ff/1", rdata_a, rdata_b, rvalid_b);
    end
    idle(); tick();
    checks++;
    if (rdata_b !== 8'h66) begin
      failures++; $display("FAIL repair_neighbour: got %h want 66", rdata_b);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      idle(); repair_req = 1; repair_addr = 6'(i); tick();
      checks++;
      if (ack_a !== 1'b1 || err_a !== 1'b0 || count_a !== 3'(i)) begin
        failures++; $display("FAIL full_fill%0d: ack=%b err=%b cnt=%0d want 1/0/%0d", i, ack_a, err_a, count_a, i);
      end
    end
    checks++;
    if (full_a !== 1'b1 || full_b !== 1'b1) begin
      failures++; $display("FAIL full_flag: got %b/%b want 1/1", full_a, full_b);
    end
    repair_addr = 7; tick();
    checks++;
    if (err_a !== 1'b1 || ack_a !== 1'b0 || count_a !== 3'd4) begin
      failures++; $display("FAIL full_err: err=%b ack=%b cnt=%0d want 1/0/4", err_a, ack_a, count_a);
    end
    repair_addr = 2; tick();
    checks++;
    if (ack_a !== 1'b1 || err_a !== 1'b0 || count_a !== 3'd4) begin
      failures++; $display("FAIL full_remapped: ack=%b err=%b cnt=%0d want 1/0/4", ack_a, err_a, count_a);
    end
    idle(); tick();
  endtask

  task automatic test_oor();
    idle(); mem_en = 1; mem_we = 1; mem_addr = 8; mem_wdata = 8'h11; tick();
    mem_addr = 40; mem_wdata = 8'h99; tick();
    mem_we = 0; tick();
    checks++;
    if (rdata_a !== 8'h00 || rvalid_a !== 1'b1) begin
      failures++; $display("FAIL oor_read: got %h/%b want 00/1", rdata_a, rvalid_a);
    end
    mem_addr = 8; tick();
    checks++;
    if (rdata_a !== 8'h11 || rdata_b !== 8'h00 || rvalid_b !== 1'b1) begin
      failures++; $display("FAIL oor_write_ignored: a=%h b=%h/%b want 11 00/1", rdata_a, rdata_b, rvalid_b);
    end
    idle(); tick();
  endtask

  task automatic test_reset_midread();
    idle(); mem_en = 1; mem_we = 1; mem_addr = 3; mem_wdata = 8'h77; tick();
    mem_we = 0; tick();
    idle(); rst = 1; tick();
    checks++;
    if ({rdata_a, rvalid_a, ack_a, err_a, full_a, count_a} !== 15'd0 ||
        {rdata_b, rvalid_b, ack_b, err_b, full_b, count_b} !== 15'd0) begin
      failures++;
      $display("FAIL midread_reset: a=%h/%b cnt=%0d b=%h/%b cnt=%0d want 0", rdata_a, rvalid_a, count_a,
               rdata_b, rvalid_b, count_b);
    end
    rst = 0; tick();
    checks++;
    if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0) begin
      failures++; $display("FAIL midread_dropped: got %b/%b want 0/0", rvalid_a, rvalid_b);
    end
    mem_en = 1; mem_addr = 3; tick();
    idle(); tick();
    checks++;
    if (rdata_b !== 8'h00 || rvalid_b !== 1'b1) begin
      failures++; $display("FAIL midread_cleared: got %h/%b want 00/1", rdata_b, rvalid_b);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst         = ($urandom_range(0, 149) == 0);
      mem_en      = ($urandom_range(0, 3) != 0);
      mem_we      = $urandom_range(0, 1) == 1;
      mem_addr    = 6'($urandom_range(0, 39));
      mem_wdata   = 8'($urandom);
      repair_req  = ($urandom_range(0, 24) == 0);
      repair_addr = 6'($urandom_range(0, 39));
      fault_we    = ($urandom_range(0, 11) == 0);
      fault_idx   = 1'($urandom_range(0, 1));
      fault_en    = $urandom_range(0, 3) != 0;
      fault_addr  = 6'($urandom_range(0, 35));
      fault_bit   = 3'($urandom_range(0, 7));
      fault_val   = $urandom_range(0, 1) == 1;
      tick();
      checks++;
      if (rvalid_a !== ea_v || rdata_a !== ea_d || rvalid_b !== eb_v || rdata_b !== eb_d ||
          ack_a !== e_ack || err_a !== e_err || ack_b !== e_ack || err_b !== e_err ||
          count_a !== 3'(nmap) || count_b !== 3'(nmap) || full_a !== (nmap == 4)) begin
        failures++;
        $display("FAIL random_c%0d: a=%h/%b b=%h/%b ack=%b err=%b cnt=%0d full=%b want a=%h/%b b=%h/%b ack=%b err=%b cnt=%0d",
                 c, rdata_a, rvalid_a, rdata_b, rvalid_b, ack_a, err_a, count_a, full_a,
                 ea_d, ea_v, eb_d, eb_v, e_ack, e_err, nmap);
      end
    end
    rst = 0; idle(); tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_fault();
    test_repair();
    test_full();
    test_oor();
    test_reset_midread();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
